// File: rtl/clock_controller_pkg.sv
// Shared types for the CPU clock-enable controller: FSM states, speed select
// encodings and button lane indices.
package clock_controller_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } ctrl_state_e;

  typedef enum logic [1:0] {
    SPD_MANUAL = 2'b00,
    SPD_VLF    = 2'b01,
    SPD_LF     = 2'b10,
    SPD_HF     = 2'b11
  } speed_sel_e;

  localparam int NUM_BTN  = 2;
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/clock_controller_debouncer.sv
// One button lane: 2-FF synchronizer, stability-count debouncer and a
// one-cycle pulse on each accepted press.
module button_debouncer
  import clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_level, r_pulse;
  logic [CW-1:0] r_cnt;
  logic          w_differs, w_adopt, w_level_nxt;

  assign w_differs   = r_sync2 != r_level;
  // Adopt on the Nth consecutive differing cycle; a match clears the count.
  assign w_adopt     = w_differs && (r_cnt == LAST);
  assign w_level_nxt = w_adopt ? r_sync2 : r_level;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      r_pulse <= rise(w_level_nxt, r_level);
      if (!w_differs || w_adopt) r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/clock_controller.sv
// CPU clock-enable controller: run/stop/halt FSM issuing single-cycle cpu_ce
// pulses from a selected divider edge or a debounced single-step button.
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        div_vlf,
  input  logic        div_lf,
  input  logic        div_hf,
  input  logic [1:0]  speed_sel,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [1:0]  ctrl_state,
  output logic [15:0] ce_count
);

  logic [NUM_BTN-1:0] w_btn, w_pulse;
  logic               w_run_pulse, w_step_pulse;

  assign w_btn[BTN_RUN]  = run_btn;
  assign w_btn[BTN_STEP] = step_btn;

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .i_btn   (w_btn[g]),
        .o_pulse (w_pulse[g])
      );
    end
  endgenerate

  assign w_run_pulse  = w_pulse[BTN_RUN];
  assign w_step_pulse = w_pulse[BTN_STEP];

  // All three history bits track every cycle, so a speed change only ever
  // exposes a genuine rising edge, never a stale one.
  logic [2:0] w_div, r_div_prev, w_div_rise;
  logic       w_tick;

  assign w_div      = {div_hf, div_lf, div_vlf};
  assign w_div_rise = w_div & ~r_div_prev;

  always_comb begin
    w_tick = 1'b0;
    case (speed_sel)
      SPD_VLF: w_tick = w_div_rise[0];
      SPD_LF:  w_tick = w_div_rise[1];
      SPD_HF:  w_tick = w_div_rise[2];
      default: w_tick = 1'b0;
    endcase
  end

  ctrl_state_e r_state, w_state_nxt;
  logic        w_ce_nxt, r_cpu_ce;
  logic [15:0] r_ce_count;

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_run_pulse)       w_state_nxt = ST_RUN;
        else if (w_step_pulse) w_ce_nxt    = 1'b1;
      end
      ST_RUN: begin
        // Halt outranks both run and the coincident tick.
        if (halt_req)         w_state_nxt = ST_HALT;
        else if (w_run_pulse) w_state_nxt = ST_STOP;
        else if (w_tick)      w_ce_nxt    = 1'b1;
      end
      ST_HALT: begin
        if (w_run_pulse) w_state_nxt = ST_STOP;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state    <= ST_STOP;
      r_cpu_ce   <= 1'b0;
      r_ce_count <= '0;
      r_div_prev <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_ce   <= w_ce_nxt;
      r_div_prev <= w_div;
      if (r_cpu_ce) r_ce_count <= r_ce_count + 16'd1;
    end
  end

  assign cpu_ce     = r_cpu_ce;
  assign ctrl_state = r_state;
  assign ce_count   = r_ce_count;

endmodule

// File: doc/clock_controller.md
CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles before a button level is accepted (20 ms at 50 MHz).
REQ-002 SHALL have port clock_in  input  1  50 MHz system clock; sole clock.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port div_vlf  input  1  1.5 Hz divided square wave, synchronous to clock_in.
REQ-005 SHALL have port div_lf  input  1  50 Hz divided square wave, synchronous to clock_in.
REQ-006 SHALL have port div_hf  input  1  1.5 kHz divided square wave, synchronous to clock_in.
REQ-007 SHALL have port speed_sel  input  2  00 manual, 01 vlf, 10 lf, 11 hf.
REQ-008 SHALL have port run_btn  input  1  asynchronous run/stop button, active-high.
REQ-009 SHALL have port step_btn  input  1  asynchronous single-step button, active-high.
REQ-010 SHALL have port halt_req  input  1  CPU halt request, level, synchronous.
REQ-011 SHALL have port cpu_ce  output  1  registered one-cycle CPU clock enable.
REQ-012 SHALL have port ctrl_state  output  2  current state for monitor: 00 STOP, 01 RUN, 10 HALT.
REQ-013 SHALL have port ce_count  output  16  number of cpu_ce pulses issued, modulo 2^16.

Function
REQ-014 SHALL pass each button through a 2-FF synchronizer, then a debouncer adopting the new level only after DEBOUNCE_CYCLES consecutive cycles differing from the current debounced level; any bounce restarts the count.
REQ-015 SHALL emit run_pulse/step_pulse: exactly one cycle on each debounced 0->1 transition; none on release.
REQ-016 SHALL register previous values of all three div inputs every cycle regardless of speed_sel; edge_x = div_x AND NOT prev_x.
REQ-017 SHALL select tick = edge of the divider chosen by speed_sel; speed_sel 00 gives tick = 0; changing speed_sel SHALL NOT create a spurious tick.
REQ-018 SHALL implement FSM STOP/RUN/HALT, next-state priority in listed order:
  - STOP: run_pulse -> RUN; else step_pulse -> cpu_ce=1 next cycle, stay STOP; halt_req ignored.
  - RUN: halt_req -> HALT; else run_pulse -> STOP; else tick -> cpu_ce=1 next cycle.
  - HALT: run_pulse -> STOP; step_pulse and tick ignored.
REQ-019 SHALL force cpu_ce=0 in any cycle following one where RUN saw halt_req=1 (no enable on halt transition).
REQ-020 SHALL assert cpu_ce for exactly one cycle per accepted tick or step; latency from div rising edge (or pulse) to cpu_ce = 1 cycle.
REQ-021 SHALL increment ce_count in the cycle cpu_ce is high; 0xFFFF wraps to 0x0000.
REQ-022 SHALL keep run_pulse and step_pulse in the same STOP cycle as: run wins, no step issued.
REQ-023 SHALL drive ctrl_state directly from the state register.

Reset
REQ-024 SHALL on reset_n=0 at a clock_in edge set state STOP, cpu_ce 0, ce_count 0, synchronizers/debounced levels 0, debounce counters 0, div prev registers 0.
REQ-025 SHALL, for reset mid-RUN, suppress any pending cpu_ce; a button held through reset SHALL produce a pulse only after DEBOUNCE_CYCLES post-reset.

Structure
REQ-026 SHALL place state enum (STOP=2'b00, RUN=2'b01, HALT=2'b10) and speed_sel enum in package clock_controller_pkg.
REQ-027 SHALL implement synchronizer+debouncer+rising-edge pulse as sub-module button_debouncer (parameter DEBOUNCE_CYCLES), instantiated twice; counter width $clog2(DEBOUNCE_CYCLES+1).
REQ-028 SHALL contain no derived clocks; all logic on clock_in.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SHALL check reset: reset_n low 2 cycles -> cpu_ce=0, ctrl_state=00, ce_count=0.
REQ-030 SHALL check step: STOP, step_btn held 10 cycles -> exactly one cpu_ce pulse, ce_count=1, state stays 00; 3-cycle glitch -> no pulse.
REQ-031 SHALL check run: run pulse, speed_sel=11, 5 div_hf rising edges -> 5 cpu_ce pulses each 1 cycle after edge, ce_count=5; speed_sel=00 -> no pulses.
REQ-032 SHALL check halt: RUN, halt_req=1 coincident with div edge -> no cpu_ce, state 10; step ignored; run pulse -> state 00.
REQ-033 SHALL check priority: run and step pulses same STOP cycle -> RUN, no cpu_ce; halt_req with run_pulse in RUN -> HALT.
REQ-034 SHALL check wrap: preload via 65536 steps -> ce_count returns to 0x0000.
